// File: rtl/wb_arb2.sv
// Two-master Wishbone B3 arbiter sharing one slave: round-robin, grant held for the whole CYC,
// with a per-access watchdog that terminates a hung access with ERR.
module wb_arb2 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int SEL_W   = DAT_W / 8
) (
    input  logic             clk,
    input  logic             rst,
    // master 0
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_m2s,
    output logic [DAT_W-1:0] m0_dat_s2m,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic             m0_we,
    input  logic [2:0]       m0_cti,
    input  logic [1:0]       m0_bte,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    output logic             m0_ack,
    output logic             m0_err,
    output logic             m0_rty,
    // master 1
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_m2s,
    output logic [DAT_W-1:0] m1_dat_s2m,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic             m1_we,
    input  logic [2:0]       m1_cti,
    input  logic [1:0]       m1_bte,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             m1_rty,
    // shared slave
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_m2s,
    input  logic [DAT_W-1:0] s_dat_s2m,
    output logic [SEL_W-1:0] s_sel,
    output logic             s_we,
    output logic [2:0]       s_cti,
    output logic [1:0]       s_bte,
    output logic             s_cyc,
    output logic             s_stb,
    input  logic             s_ack,
    input  logic             s_err,
    input  logic             s_rty,
    output logic [1:0]       gnt
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t           state, state_nxt;
    logic             last_gnt;
    logic [CNT_W-1:0] wd_cnt;

    logic sel1, busy, req_cyc, req_stb, active, term, wd_hit;

    assign sel1    = (state == GNT1);
    assign busy    = (state != IDLE);
    assign req_cyc = sel1 ? m1_cyc : m0_cyc;
    assign req_stb = sel1 ? m1_stb : m0_stb;
    assign active  = busy && req_cyc && req_stb;
    assign term    = s_ack || s_err || s_rty;
    assign wd_hit  = (TIMEOUT != 0) && active && (wd_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        // NOTE: default assigned first so no path through this block infers a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || last_gnt)) state_nxt = GNT0;
                else if (m1_cyc)                     state_nxt = GNT1;
            end
            GNT0:    if (!m0_cyc) state_nxt = IDLE;
            GNT1:    if (!m1_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wd_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == GNT0 && !m0_cyc) last_gnt <= 1'b0;
            if (state == GNT1 && !m1_cyc) last_gnt <= 1'b1;
            if (!active || term || wd_hit)    wd_cnt <= '0;
            else if (wd_cnt != {CNT_W{1'b1}}) wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Request mux; the slave strobe is masked on the watchdog cycle so the dead access is dropped.
    assign s_adr     = sel1 ? m1_adr     : m0_adr;
    assign s_dat_m2s = sel1 ? m1_dat_m2s : m0_dat_m2s;
    assign s_sel     = sel1 ? m1_sel     : m0_sel;
    assign s_we      = sel1 ? m1_we      : m0_we;
    assign s_cti     = sel1 ? m1_cti     : m0_cti;
    assign s_bte     = sel1 ? m1_bte     : m0_bte;
    assign s_cyc     = busy && req_cyc;
    assign s_stb     = active && !wd_hit;

    // A real ack on the timeout cycle wins over the synthesized err.
    assign m0_ack = (state == GNT0) && s_ack;
    assign m0_err = (state == GNT0) && (s_err || (wd_hit && !s_ack));
    assign m0_rty = (state == GNT0) && s_rty;
    assign m1_ack = sel1 && s_ack;
    assign m1_err = sel1 && (s_err || (wd_hit && !s_ack));
    assign m1_rty = sel1 && s_rty;

    assign m0_dat_s2m = s_dat_s2m;
    assign m1_dat_s2m = s_dat_s2m;
    assign gnt        = {sel1, state == GNT0};

endmodule
